multicore_ctrl: RTL and testbench
=================================

# multicore_ctrl

Parametrised controller for an array of identical processing cores (e.g. `rede_taylor` instances) sharing one input stream. It releases per-core resets in a staggered sequence so that core phases are offset by a fixed number of cycles. It captures each core's output words into per-core holding registers and drains them through a round-robin arbiter onto a single valid/ready output port. Unlike the previous priority mux, it never silently drops a word: collisions are buffered, and overflow is flagged and counted.

## Interface
- `N_CORES`, 34, number of cores (≥2)
- `OUT_W`, 28, core output data width (signed)
- `EN_W`, 4, core output-enable code width
- `EN_CODE`, 1, `out_en` value meaning "word valid"
- `STAGGER`, 10, cycles between successive core reset releases (≥1)
- `CNT_W`, 16, width of the lost-word counter
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `core_rst` out N_CORES: per-core active-high reset; bit k drives core k.
- `core_io_out` in N_CORES*OUT_W: core k data at bits [k*OUT_W +: OUT_W].
- `core_out_en` in N_CORES*EN_W: core k enable code at bits [k*EN_W +: EN_W].
- `m_data` out OUT_W: selected word.
- `m_core` out $clog2(N_CORES): index of the source core.
- `m_valid` out 1: output word valid.
- `m_ready` in 1: downstream accepts the word.
- `boot_done` out 1: all cores released.
- `overflow` out 1: sticky, set on any lost word.
- `lost_cnt` out CNT_W: saturating count of lost words.

## Operation
- Reset values:
  - `core_rst` all 1s.
  - `m_data`, `m_core`, `m_valid`, `boot_done`, `overflow`, `lost_cnt` all 0.
  - Holding registers empty; arbiter pointer 0; sequencer in BOOT with idx=0, cnt=0.
- Sequencer FSM, BOOT → RUN:
  - In BOOT, `core_rst[idx]` clears on the current edge; `cnt` increments each edge.
  - When `cnt==STAGGER-1`: `cnt`←0 and `idx`←`idx`+1.
  - When `idx==N_CORES-1` and `cnt==STAGGER-1`, go to RUN and set `boot_done`.
  - RUN is terminal until `rst_n`. Released cores are never re-reset.
- Capture:
  - Core k offers a word in a cycle when `core_out_en[k]==EN_CODE` and `core_rst[k]==0`.
  - Every such cycle is one word. Other `out_en` codes are ignored.
  - An offered word loads hold[k] if hold[k] is empty, or if hold[k] is being drained on the same edge.
  - Otherwise the new word is dropped and the old word is kept: `overflow`←1 and `lost_cnt`++, saturating at all-ones.
  - Several cores may load on the same edge; nothing is lost while each has a free holder.
- Drain:
  - The output register loads when `!m_valid || m_ready`.
  - Grant goes to the first non-empty hold[j], searching j = ptr, ptr+1, …, wrapping modulo N_CORES.
  - On grant: load `m_data`/`m_core`, empty hold[j], ptr←(j+1) mod N_CORES.
  - If no holder is valid, `m_valid`←0.
  - `m_valid && !m_ready` holds `m_data`/`m_core` stable.
- Arithmetic: no data modification; data passes through bit-exact.
- `rst_n` low at any time, including mid-boot or mid-transfer, immediately forces the reset values. Pending words are discarded.

## Timing
- Edge 1 is the first rising edge with `rst_n` high.
- Core k's `core_rst` falls at edge k·STAGGER+1.
- `boot_done` rises at edge N_CORES·STAGGER+1.
- Latency: a word offered before edge e is captured at edge e. It appears on `m_*` after edge e+1 at the earliest.
- Throughput: one word per cycle with `m_ready` held high.
- The round-robin guarantees each non-empty holder is granted within N_CORES accepted transfers.

## Structure
- Package `multicore_pkg`:
  - default `EN_CODE` constant
  - index-width localparam helper
  - BOOT/RUN state enum
- Sub-module `rr_arbiter`:
  - parameter N
  - inputs: `req[N]`, `advance`
  - output: one-hot `grant`
  - internal rotating pointer, reset to 0
- Top holds the sequencer, holding registers, output register and counters.

## Test plan
Bench configuration: N_CORES=4, STAGGER=3 unless noted.
- Boot: release `rst_n` → `core_rst` falls at edges 1, 4, 7, 10; `boot_done` rises at edge 13; `m_valid` stays 0 throughout.
- Ignored word: core 2 offers 0x0ABCDEF while still in reset → not captured, `m_valid` stays 0. The same word after release → `m_data`=0x0ABCDEF, `m_core`=2, two edges later.
- Collision: cores 0, 1, 3 offer 5, 6, 7 on the same edge with `m_ready`=1 → output sequence (0,5), (1,6), (3,7) on consecutive cycles; `overflow`=0.
- Fairness: all four cores offer every cycle with `m_ready` high → the granted `m_core` sequence strictly rotates 0, 1, 2, 3, 0, …
- Backpressure/overflow: `m_ready`=0 while core 1 offers 3 consecutive words → first word on `m_*`, second held, third lost; `overflow`=1, `lost_cnt`=1. Raise `m_ready` → first and second delivered, in order.
- Async reset: assert `rst_n` low mid-transfer between edges → all outputs reach their reset values before the next edge; boot restarts at core 0.

Source files
------------

// File: rtl/multicore_pkg.sv
// Shared constants, types and helpers for the multicore controller slice.
package multicore_pkg;

  localparam int unsigned EN_CODE_DEF = 1;

  typedef enum logic {
    ST_BOOT,
    ST_RUN
  } seq_state_e;

  // Width of an index into n items; never less than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after the
// rotating pointer; pointer moves past the winner when advance is asserted.
module rr_arbiter
  import multicore_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int unsigned IW = idx_w(N);

  logic [IW-1:0] ptr_q, ptr_d;

  always_comb begin
    int unsigned j;
    logic        found;
    j     = 0;
    found = 1'b0;
    grant = '0;
    ptr_d = ptr_q;
    for (int unsigned i = 0; i < N; i++) begin
      j = 32'(ptr_q) + i;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        ptr_d    = (j == N - 1) ? '0 : IW'(j + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (advance && |req) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/multicore_ctrl.sv
// Staggered core reset release plus lossless-where-possible collection of core
// output words into per-core holders drained round-robin onto one valid/ready port.
module multicore_ctrl
  import multicore_pkg::*;
#(
  parameter int unsigned N_CORES = 34,
  parameter int unsigned OUT_W   = 28,
  parameter int unsigned EN_W    = 4,
  parameter int unsigned EN_CODE = EN_CODE_DEF,
  parameter int unsigned STAGGER = 10,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic [N_CORES-1:0]         core_rst,
  input  logic [N_CORES*OUT_W-1:0]   core_io_out,
  input  logic [N_CORES*EN_W-1:0]    core_out_en,
  output logic [OUT_W-1:0]           m_data,
  output logic [$clog2(N_CORES)-1:0] m_core,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic                       boot_done,
  output logic                       overflow,
  output logic [CNT_W-1:0]           lost_cnt
);

  localparam int unsigned    IW     = idx_w(N_CORES);
  localparam int unsigned    SW     = idx_w(STAGGER);
  localparam logic [EN_W-1:0] EN_VAL = EN_W'(EN_CODE);

  seq_state_e         state_q;
  logic [IW-1:0]      idx_q;
  logic [SW-1:0]      cnt_q;
  logic [N_CORES-1:0] core_rst_q;
  logic               boot_done_q;

  // boot_done is registered off the RUN state, so it rises one edge after
  // the last core's release window closes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_BOOT;
      idx_q       <= '0;
      cnt_q       <= '0;
      core_rst_q  <= '1;
      boot_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_BOOT: begin
          core_rst_q[idx_q] <= 1'b0;
          if (cnt_q == SW'(STAGGER - 1)) begin
            cnt_q <= '0;
            if (idx_q == IW'(N_CORES - 1)) state_q <= ST_RUN;
            else                           idx_q   <= idx_q + 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RUN:  boot_done_q <= 1'b1;
        default: state_q     <= ST_BOOT;
      endcase
    end
  end

  logic [N_CORES-1:0]            hold_vld_q;
  logic [N_CORES-1:0][OUT_W-1:0] hold_dat_q;
  logic [OUT_W-1:0]              m_data_q;
  logic [IW-1:0]                 m_core_q;
  logic                          m_valid_q;
  logic                          overflow_q;
  logic [CNT_W-1:0]              lost_cnt_q, lost_cnt_d;

  logic [N_CORES-1:0] offer, grant, drain, take, lost;
  logic               load_out;
  logic [IW-1:0]      gidx;

  rr_arbiter #(
    .N(N_CORES)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (hold_vld_q),
    .advance (load_out),
    .grant   (grant)
  );

  always_comb begin
    load_out   = !m_valid_q || m_ready;
    offer      = '0;
    drain      = '0;
    take       = '0;
    lost       = '0;
    gidx       = '0;
    lost_cnt_d = lost_cnt_q;
    for (int unsigned k = 0; k < N_CORES; k++) begin
      offer[k] = (core_out_en[k*EN_W +: EN_W] == EN_VAL) && !core_rst_q[k];
      drain[k] = load_out && grant[k];
      take[k]  = offer[k] && (!hold_vld_q[k] || drain[k]);
      lost[k]  = offer[k] && !take[k];
      if (grant[k]) gidx = IW'(k);
      if (lost[k] && lost_cnt_d != '1) lost_cnt_d = lost_cnt_d + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_vld_q <= '0;
      hold_dat_q <= '0;
      m_data_q   <= '0;
      m_core_q   <= '0;
      m_valid_q  <= 1'b0;
      overflow_q <= 1'b0;
      lost_cnt_q <= '0;
    end else begin
      for (int unsigned k = 0; k < N_CORES; k++) begin
        if (take[k]) begin
          hold_vld_q[k] <= 1'b1;
          hold_dat_q[k] <= core_io_out[k*OUT_W +: OUT_W];
        end else if (drain[k]) begin
          hold_vld_q[k] <= 1'b0;
        end
      end
      if (load_out) begin
        m_valid_q <= |hold_vld_q;
        if (|hold_vld_q) begin
          m_data_q <= hold_dat_q[gidx];
          m_core_q <= gidx;
        end
      end
      if (|lost) overflow_q <= 1'b1;
      lost_cnt_q <= lost_cnt_d;
    end
  end

  assign core_rst  = core_rst_q;
  assign boot_done = boot_done_q;
  assign m_data    = m_data_q;
  assign m_core    = m_core_q;
  assign m_valid   = m_valid_q;
  assign overflow  = overflow_q;
  assign lost_cnt  = lost_cnt_q;

endmodule

// File: tb/tb_multicore_ctrl.sv
// Directed bench for multicore_ctrl with 4 cores and a 3-cycle stagger.
module tb_multicore_ctrl;

  logic        clk;
  logic        rst_n;
  logic [3:0]  core_rst;
  logic [111:0] core_io_out;
  logic [15:0] core_out_en;
  logic [27:0] m_data;
  logic [1:0]  m_core;
  logic        m_valid;
  logic        m_ready;
  logic        boot_done;
  logic        overflow;
  logic [15:0] lost_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  multicore_ctrl #(
    .N_CORES (4),
    .OUT_W   (28),
    .EN_W    (4),
    .EN_CODE (1),
    .STAGGER (3),
    .CNT_W   (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .core_rst    (core_rst),
    .core_io_out (core_io_out),
    .core_out_en (core_out_en),
    .m_data      (m_data),
    .m_core      (m_core),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .boot_done   (boot_done),
    .overflow    (overflow),
    .lost_cnt    (lost_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input int k, input logic [27:0] d, input logic [3:0] en);
    core_io_out[k*28 +: 28] = d;
    core_out_en[k*4 +: 4]   = en;
  endtask

  task automatic clear_offers();
    core_io_out = '0;
    core_out_en = '0;
  endtask

  // Reset, release between edges, then run through edge 13 (boot_done high).
  task automatic boot();
    rst_n = 1'b0;
    clear_offers();
    m_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    repeat (13) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m_ready = 1'b1;
    clear_offers();
    #12;
    n_cmp++; if (core_rst !== 4'hF) begin n_bad++; $display("FAIL reset core_rst: got %h want %h", core_rst, 4'hF); end
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL reset m_valid: got %b want 0", m_valid); end
    n_cmp++; if (m_data !== 28'd0) begin n_bad++; $display("FAIL reset m_data: got %h want 0", m_data); end
    n_cmp++; if (m_core !== 2'd0) begin n_bad++; $display("FAIL reset m_core: got %0d want 0", m_core); end
    n_cmp++; if (boot_done !== 1'b0) begin n_bad++; $display("FAIL reset boot_done: got %b want 0", boot_done); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset overflow: got %b want 0", overflow); end
    n_cmp++; if (lost_cnt !== 16'd0) begin n_bad++; $display("FAIL reset lost_cnt: got %0d want 0", lost_cnt); end
  endtask

  task automatic test_boot();
    logic [3:0] exp_rst;
    tick();
    rst_n = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      tick();
      for (int k = 0; k < 4; k++) exp_rst[k] = (e < 3 * k + 1);
      n_cmp++; if (core_rst !== exp_rst) begin n_bad++; $display("FAIL boot core_rst edge %0d: got %b want %b", e, core_rst, exp_rst); end
      n_cmp++; if (boot_done !== (e >= 13)) begin n_bad++; $display("FAIL boot boot_done edge %0d: got %b want %b", e, boot_done, (e >= 13)); end
      n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL boot m_valid edge %0d: got %b want 0", e, m_valid); end
    end
  endtask

  task automatic test_ignored_word();
    rst_n = 1'b0;
    clear_offers();
    m_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    set_core(2, 28'h0ABCDEF, 4'd1);
    repeat (3) tick();
    set_core(2, 28'h0, 4'd0);
    repeat (2) tick();
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL ignored m_valid in reset: got %b want 0", m_valid); end
    repeat (8) tick();
    set_core(2, 28'h0ABCDEF, 4'd1);
    tick();
    set_core(2, 28'h0, 4'd0);
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL ignored latency m_valid: got %b want 0", m_valid); end
    tick();
    n_cmp++; if (m_valid !== 1'b1) begin n_bad++; $display("FAIL ignored m_valid: got %b want 1", m_valid); end
    n_cmp++; if (m_data !== 28'h0ABCDEF) begin n_bad++; $display("FAIL ignored m_data: got %h want 0abcdef", m_data); end
    n_cmp++; if (m_core !== 2'd2) begin n_bad++; $display("FAIL ignored m_core: got %0d want 2", m_core); end
    tick();
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL ignored drain m_valid: got %b want 0", m_valid); end
  endtask

  task automatic test_collision();
    logic [1:0]  exp_core [3] = '{2'd0, 2'd1, 2'd3};
    logic [27:0] exp_data [3] = '{28'd5, 28'd6, 28'd7};
    boot();
    set_core(0, 28'd5, 4'd1);
    set_core(1, 28'd6, 4'd1);
    set_core(3, 28'd7, 4'd1);
    tick();
    clear_offers();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (m_valid !== 1'b1) begin n_bad++; $display("FAIL collision m_valid #%0d: got %b want 1", i, m_valid); end
      n_cmp++; if (m_core !== exp_core[i]) begin n_bad++; $display("FAIL collision m_core #%0d: got %0d want %0d", i, m_core, exp_core[i]); end
      n_cmp++; if (m_data !== exp_data[i]) begin n_bad++; $display("FAIL collision m_data #%0d: got %0d want %0d", i, m_data, exp_data[i]); end
    end
    tick();
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL collision idle m_valid: got %b want 0", m_valid); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL collision overflow: got %b want 0", overflow); end
  endtask

  task automatic test_fairness();
    boot();
    for (int k = 0; k < 4; k++) set_core(k, 28'(100 + k), 4'd1);
    tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++; if (m_valid !== 1'b1) begin n_bad++; $display("FAIL fairness m_valid #%0d: got %b want 1", i, m_valid); end
      n_cmp++; if (m_core !== 2'(i % 4)) begin n_bad++; $display("FAIL fairness m_core #%0d: got %0d want %0d", i, m_core, i % 4); end
      n_cmp++; if (m_data !== 28'(100 + i % 4)) begin n_bad++; $display("FAIL fairness m_data #%0d: got %0d want %0d", i, m_data, 100 + i % 4); end
    end
    clear_offers();
  endtask

  task automatic test_backpressure();
    boot();
    m_ready = 1'b0;
    set_core(1, 28'd11, 4'd1);
    tick();
    set_core(1, 28'd22, 4'd1);
    tick();
    set_core(1, 28'd33, 4'd1);
    tick();
    clear_offers();
    n_cmp++; if (m_valid !== 1'b1) begin n_bad++; $display("FAIL bp m_valid: got %b want 1", m_valid); end
    n_cmp++; if (m_data !== 28'd11) begin n_bad++; $display("FAIL bp first m_data: got %0d want 11", m_data); end
    n_cmp++; if (m_core !== 2'd1) begin n_bad++; $display("FAIL bp m_core: got %0d want 1", m_core); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL bp overflow: got %b want 1", overflow); end
    n_cmp++; if (lost_cnt !== 16'd1) begin n_bad++; $display("FAIL bp lost_cnt: got %0d want 1", lost_cnt); end
    tick();
    n_cmp++; if (m_data !== 28'd11) begin n_bad++; $display("FAIL bp stall m_data: got %0d want 11", m_data); end
    m_ready = 1'b1;
    tick();
    n_cmp++; if (m_valid !== 1'b1) begin n_bad++; $display("FAIL bp second m_valid: got %b want 1", m_valid); end
    n_cmp++; if (m_data !== 28'd22) begin n_bad++; $display("FAIL bp second m_data: got %0d want 22", m_data); end
    tick();
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL bp empty m_valid: got %b want 0", m_valid); end
    n_cmp++; if (lost_cnt !== 16'd1) begin n_bad++; $display("FAIL bp final lost_cnt: got %0d want 1", lost_cnt); end
  endtask

  // Three words lost per cycle once every holder is full; 22000 cycles pass 65535.
  task automatic test_saturation();
    boot();
    for (int k = 0; k < 4; k++) set_core(k, 28'(200 + k), 4'd1);
    repeat (22000) tick();
    clear_offers();
    n_cmp++; if (lost_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL sat lost_cnt: got %h want ffff", lost_cnt); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL sat overflow: got %b want 1", overflow); end
  endtask

  task automatic test_async_reset();
    boot();
    m_ready = 1'b0;
    set_core(1, 28'd44, 4'd1);
    tick();
    set_core(1, 28'd55, 4'd1);
    tick();
    set_core(1, 28'd66, 4'd1);
    tick();
    clear_offers();
    n_cmp++; if (m_valid !== 1'b1) begin n_bad++; $display("FAIL async pre m_valid: got %b want 1", m_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (core_rst !== 4'hF) begin n_bad++; $display("FAIL async core_rst: got %h want f", core_rst); end
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL async m_valid: got %b want 0", m_valid); end
    n_cmp++; if (m_data !== 28'd0) begin n_bad++; $display("FAIL async m_data: got %0d want 0", m_data); end
    n_cmp++; if (m_core !== 2'd0) begin n_bad++; $display("FAIL async m_core: got %0d want 0", m_core); end
    n_cmp++; if (boot_done !== 1'b0) begin n_bad++; $display("FAIL async boot_done: got %b want 0", boot_done); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL async overflow: got %b want 0", overflow); end
    n_cmp++; if (lost_cnt !== 16'd0) begin n_bad++; $display("FAIL async lost_cnt: got %0d want 0", lost_cnt); end
    tick();
    rst_n = 1'b1;
    m_ready = 1'b1;
    tick();
    n_cmp++; if (core_rst !== 4'b1110) begin n_bad++; $display("FAIL async reboot edge1 core_rst: got %b want 1110", core_rst); end
    repeat (2) tick();
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL async discarded m_valid: got %b want 0", m_valid); end
    tick();
    n_cmp++; if (core_rst !== 4'b1100) begin n_bad++; $display("FAIL async reboot edge4 core_rst: got %b want 1100", core_rst); end
  endtask

  initial begin
    rst_n = 1'b0;
    m_ready = 1'b1;
    clear_offers();
    test_reset();
    test_boot();
    test_ignored_word();
    test_collision();
    test_fairness();
    test_backpressure();
    test_saturation();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
